// File: rtl/game_pkg.sv
// game_pkg: shared state encodings and constants for the mole game blocks
//   state_e   : IDLE/GAP/UP/HIT/OVER scheduler states
//   NUM_MOLES : number of mole LEDs/buttons
//   LFSR_SEED : reset value of the mole-selection LFSR
//   LFSR_TAPS : feedback mask for taps 8,6,5,4 (bits 7,5,4,3)
package game_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        UP   = 3'd2,
        HIT  = 3'd3,
        OVER = 3'd4
    } state_e;
    localparam int NUM_MOLES = 4;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, shift-left with XOR feedback of the tap mask
//   clk   : clock
//   reset : async active-high, loads SEED
//   en_i  : advance one step this cycle
//   q_o   : current register value
module lfsr8
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED,
    parameter logic [7:0] TAPS = LFSR_TAPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output logic [7:0] q_o
);
    logic [7:0] q_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= SEED;
        else if (en_i) q_q <= {q_q[6:0], ^(q_q & TAPS)};
    assign q_o = q_q;
endmodule

// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: spaces, selects and times moles, judges hits/misses, scores and runs the game clock
//   clk, reset  : clock, async active-high reset
//   start       : one-cycle pulse, starts a game from IDLE or OVER
//   btn         : synchronised mole buttons, active-high
//   mole_onehot : lit mole (one-hot or zero), registered
//   score       : hits this game, saturating
//   misses      : timeouts plus wrong presses, saturating
//   hit_pulse   : one-cycle pulse per scored hit
//   game_over   : high in OVER
//   busy        : high in GAP, UP or HIT
//   state       : current state encoding
module mole_round_scheduler
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int GAP_TICKS  = 400,
    parameter int UP_TICKS   = 800,
    parameter int GAME_TICKS = 30000,
    parameter int SCORE_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    output logic [NUM_MOLES-1:0] mole_onehot,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 game_over,
    output logic                 busy,
    output logic [2:0]           state
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int UW = $clog2(UP_TICKS + 1);
    localparam int TW = $clog2(GAME_TICKS + 1);
    localparam int IW = $clog2(NUM_MOLES);
    localparam logic [SCORE_W-1:0] SAT = '1;

    state_e               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [UW-1:0]        up_q, up_d;
    logic [TW-1:0]        game_q, game_d;
    logic [SCORE_W-1:0]   score_q, score_d, miss_q, miss_d;
    logic [SCORE_W:0]     miss_sum;
    logic [NUM_MOLES-1:0] mole_q, mole_d, btn_q, rise;
    logic [IW-1:0]        idx_q, idx_d, cand, pick;
    logic                 prev_v_q, prev_v_d, hit_q, hit_d;
    logic [7:0]           lfsr;
    logic                 unused_lfsr;
    logic                 tick, go, play, last, hit, wrong, timeout, appear;

    lfsr8 u_lfsr (
        .clk  (clk),
        .reset(reset),
        .en_i (1'b1),
        .q_o  (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:IW];
    assign tick    = presc_q == PW'(TICK_DIV - 1);
    assign rise    = btn & ~btn_q;
    assign cand    = lfsr[IW-1:0];
    // never light the same mole twice in a row; the first mole of a power-up has no predecessor
    assign pick    = (prev_v_q && cand == idx_q) ? cand + 1'b1 : cand;
    assign go      = start && (state_q == IDLE || state_q == OVER);
    assign play    = state_q inside {GAP, UP, HIT};
    // the final game tick overrides any hit, miss or mole appearance in the same cycle
    assign last    = play && tick && game_q == TW'(1);
    assign hit     = state_q == UP && |(rise & mole_q);
    assign wrong   = state_q == UP && |rise && !hit;
    assign timeout = state_q == UP && tick && up_q == UW'(1) && !hit;
    assign appear  = state_q == GAP && tick && gap_q == GW'(1);
    assign miss_sum = {1'b0, miss_q} + (SCORE_W + 1)'(wrong) + (SCORE_W + 1)'(timeout);

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = go ? GAP : last ? OVER : hit ? HIT : (timeout || state_q == HIT) ? GAP : appear ? UP : state_q;
    end

    always_comb begin
        presc_d  = (go || tick) ? '0 : presc_q + 1'b1;
        game_d   = go ? TW'(GAME_TICKS) : (play && tick) ? game_q - 1'b1 : game_q;
        gap_d    = (go || timeout || state_q == HIT) ? GW'(GAP_TICKS) : (state_q == GAP && tick) ? gap_q - 1'b1 : gap_q;
        up_d     = appear ? UW'(UP_TICKS) : (state_q == UP && tick) ? up_q - 1'b1 : up_q;
        idx_d    = (appear && !last) ? pick : idx_q;
        prev_v_d = prev_v_q || (appear && !last);
        mole_d   = state_d != UP ? '0 : appear ? NUM_MOLES'(1) << pick : mole_q;
        hit_d    = hit && !last;
        score_d  = go ? '0 : (hit && !last && score_q != SAT) ? score_q + 1'b1 : score_q;
        miss_d   = go ? '0 : last ? miss_q : miss_sum[SCORE_W] ? SAT : miss_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            presc_q  <= '0;
            gap_q    <= '0;
            up_q     <= '0;
            game_q   <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            mole_q   <= '0;
            btn_q    <= '0;
            idx_q    <= '0;
            prev_v_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            gap_q    <= gap_d;
            up_q     <= up_d;
            game_q   <= game_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            mole_q   <= mole_d;
            btn_q    <= btn;
            idx_q    <= idx_d;
            prev_v_q <= prev_v_d;
            hit_q    <= hit_d;
        end

    assign mole_onehot = mole_q;
    assign score       = score_q;
    assign misses      = miss_q;
    assign hit_pulse   = hit_q;
    assign game_over   = state_q == OVER;
    assign busy        = play;
    assign state       = state_q;
endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb_mole_round_scheduler: scoreboard bench, behavioural game model vs two DUTs (8-bit and 2-bit counters)
module tb_mole_round_scheduler;
    localparam int TD = 2, GT = 2, UT = 3, GMT = 40;

    typedef struct packed {
        logic [3:0] mole;
        logic [7:0] sc;
        logic [7:0] mi;
        logic       hp;
        logic       go;
        logic       busy;
        logic [2:0] st;
    } obs_t;
    typedef struct packed { obs_t a; obs_t b; } snap_t;
    typedef struct { snap_t s; int cyc; } exp_t;

    logic clk = 0, reset = 1, start = 0;
    logic [3:0] btn = '0;
    logic [3:0] mole, mole_s;
    logic [7:0] score, misses;
    logic [1:0] score_s, misses_s;
    logic hp, go, busy, hp_s, go_s, busy_s;
    logic [2:0] st, st_s;
    int checks = 0, failures = 0, cyc = 0;
    exp_t q[$];

    bit m_play, m_over, m_hit, m_hp;
    int m_lit, m_prev, m_presc, m_gap, m_up, m_game, m_score, m_miss;
    logic [7:0] m_lfsr;
    logic [3:0] m_btn;
    snap_t m_last;

    always #5 clk = ~clk;

    mole_round_scheduler #(.TICK_DIV(TD), .GAP_TICKS(GT), .UP_TICKS(UT), .GAME_TICKS(GMT), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .mole_onehot(mole), .score(score),
        .misses(misses), .hit_pulse(hp), .game_over(go), .busy(busy), .state(st));

    mole_round_scheduler #(.TICK_DIV(TD), .GAP_TICKS(GT), .UP_TICKS(UT), .GAME_TICKS(GMT), .SCORE_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .mole_onehot(mole_s), .score(score_s),
        .misses(misses_s), .hit_pulse(hp_s), .game_over(go_s), .busy(busy_s), .state(st_s));

    function automatic snap_t dut_snap();
        snap_t s;
        s.a = '{mole, score, misses, hp, go, busy, st};
        s.b = '{mole_s, {6'b0, score_s}, {6'b0, misses_s}, hp_s, go_s, busy_s, st_s};
        return s;
    endfunction

    // Expected outputs: true hit/miss totals capped at each counter's all-ones value.
    function automatic snap_t model_snap();
        snap_t s;
        s.a.mole = m_lit >= 0 ? 4'b1 << m_lit : 4'b0;
        s.a.sc   = 8'(m_score > 255 ? 255 : m_score);
        s.a.mi   = 8'(m_miss > 255 ? 255 : m_miss);
        s.a.hp   = m_hp;
        s.a.go   = m_over;
        s.a.busy = m_play;
        s.a.st   = m_over ? 3'd4 : m_hit ? 3'd3 : m_lit >= 0 ? 3'd2 : m_play ? 3'd1 : 3'd0;
        s.b      = s.a;
        s.b.sc   = 8'(m_score > 3 ? 3 : m_score);
        s.b.mi   = 8'(m_miss > 3 ? 3 : m_miss);
        return s;
    endfunction

    task automatic model_reset();
        m_play = 0; m_over = 0; m_hit = 0; m_hp = 0;
        m_lit = -1; m_prev = -1; m_presc = 0; m_gap = 0; m_up = 0; m_game = 0;
        m_score = 0; m_miss = 0; m_lfsr = 8'hA5; m_btn = '0;
        q.delete();
        m_last = model_snap();
    endtask

    // One clock of the game rules, using the input values sampled at this edge.
    task automatic model_step();
        logic [3:0] rise;
        bit tick, started;
        int cand, pick;
        rise = btn & ~m_btn;
        m_btn = btn;
        tick = m_presc == TD - 1;
        cand = int'(m_lfsr[1:0]);
        pick = (cand == m_prev) ? (cand + 1) % 4 : cand;
        started = 0;
        m_hp = 0;
        if (!m_play) begin
            if (start) begin
                started = 1; m_play = 1; m_over = 0; m_score = 0; m_miss = 0;
                m_game = GMT; m_gap = GT; m_lit = -1; m_hit = 0;
            end
        end else if (tick && m_game == 1) begin
            m_play = 0; m_over = 1; m_lit = -1; m_hit = 0;
        end else begin
            if (tick) m_game--;
            if (m_hit) begin
                m_hit = 0; m_gap = GT;
            end else if (m_lit < 0) begin
                if (tick) begin
                    if (m_gap == 1) begin m_lit = pick; m_prev = pick; m_up = UT; end
                    else m_gap--;
                end
            end else if (rise[m_lit]) begin
                m_score++; m_hp = 1; m_hit = 1; m_lit = -1;
            end else begin
                if (rise != 0) m_miss++;
                if (tick) begin
                    if (m_up == 1) begin m_miss++; m_lit = -1; m_gap = GT; end
                    else m_up--;
                end
            end
        end
        m_presc = (started || tick) ? 0 : m_presc + 1;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    initial begin
        snap_t s;
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) model_reset();
            else model_step();
            s = model_snap();
            if (s != m_last) begin
                q.push_back('{s, cyc});
                m_last = s;
            end
        end
    end

    initial begin
        snap_t p, d;
        exp_t e;
        logic [3:0] last_mole;
        p = '0;
        last_mole = '0;
        forever begin
            @(negedge clk);
            d = dut_snap();
            if (reset) begin
                last_mole = '0;
            end else if (d !== p) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, d);
                end else begin
                    e = q.pop_front();
                    if (e.s !== d || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL snapshot cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, d, e.s, e.cyc);
                    end
                end
                if (d.a.mole != 0 && p.a.mole == 0) begin
                    checks++;
                    if (!$onehot(d.a.mole) || d.a.mole == last_mole) begin
                        failures++;
                        $display("FAIL no_repeat cyc=%0d got=%b prev=%b", cyc, d.a.mole, last_mole);
                    end
                    last_mole = d.a.mole;
                end
            end else if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_change cyc=%0d got=%h exp=%h", cyc, d, e.s);
            end
            p = d;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_mole"}, int'(mole), 0);
        chk({nm, "_score"}, int'(score), 0);
        chk({nm, "_misses"}, int'(misses), 0);
        chk({nm, "_hit"}, int'(hp), 0);
        chk({nm, "_over"}, int'(go), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_state"}, int'(st), 0);
    endtask

    task automatic do_start();
        step();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wait_lit(string nm);
        int n = 0;
        while (mole == 0 && n < 100) begin step(); n++; end
        chk(nm, int'(mole != 0), 1);
    endtask

    task automatic wait_over(string nm);
        int n = 0;
        while (!go && n < 200) begin step(); n++; end
        chk(nm, int'(go), 1);
    endtask

    initial begin
        int m0, n;
        repeat (3) step();
        chk_zero("reset");
        reset = 0;
        step();

        do_start();
        chk("start_state", int'(st), 1);
        repeat (3) step();
        chk("gap_dark", int'(mole), 0);
        step();
        chk("first_mole_onehot", int'($onehot(mole)), 1);
        chk("first_mole_busy", int'(busy), 1);
        chk("first_mole_over", int'(go), 0);
        btn = mole;
        step();
        btn = '0;
        chk("hit_pulse", int'(hp), 1);
        chk("hit_score", int'(score), 1);
        chk("hit_state", int'(st), 3);
        step();
        chk("hit_pulse_end", int'(hp), 0);
        chk("after_hit_state", int'(st), 1);
        chk("after_hit_dark", int'(mole), 0);

        wait_lit("wrong_wait");
        m0 = int'(misses);
        btn = {mole[2:0], mole[3]};
        step();
        chk("wrong_press", int'(misses), m0 + 1);
        n = 0;
        while (mole != 0 && n < 20) begin step(); n++; end
        btn = '0;
        chk("timeout_miss", int'(misses), m0 + 2);
        chk("timeout_state", int'(st), 1);
        wait_over("game_a_over");

        do_start();
        repeat (79) step();
        chk("lit_at_end", int'(mole != 0), 1);
        btn = mole;
        step();
        btn = '0;
        chk("end_state", int'(st), 4);
        chk("end_over", int'(go), 1);
        chk("end_score", int'(score), 0);
        chk("end_misses", int'(misses), 7);

        do_start();
        chk("restart_score", int'(score), 0);
        chk("restart_misses", int'(misses), 0);
        n = 0;
        while (!go && n < 200) begin
            btn = (btn == 0) ? mole : 4'b0;
            step();
            n++;
        end
        btn = '0;
        chk("sat_over", int'(go), 1);
        chk("sat_score_w2", int'(score_s), 3);
        chk("sat_score_w8_ge5", int'(score >= 5), 1);

        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 9);
            btn = n < 3 ? mole : n == 3 ? 4'($urandom) : n < 6 ? btn : 4'b0;
            start = $urandom_range(0, 19) == 0;
            step();
        end
        start = 0;
        btn = '0;

        do_start();
        wait_lit("reset_wait");
        @(posedge clk);
        #2 reset = 1;
        #1 chk_zero("async_reset");
        step();
        step();
        reset = 0;
        do_start();
        for (int i = 0; i < 30; i++) begin
            btn = $urandom_range(0, 2) == 0 ? mole : 4'b0;
            step();
        end
        btn = '0;
        repeat (3) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Sequences one whack-a-mole game: spaces moles in time, picks which mole lights, times how long it stays up, judges button hits and misses, keeps score and runs the game countdown.
- Sits between the game-state FSM (which supplies start and consumes game_over) and the LED/button datapath (mole_onehot out, btn in).
- Generates its own timebase and pseudo-random mole selection.

Parameters:
- TICK_DIV, 50000, clk cycles per game tick (1 ms at 50 MHz); minimum 2.
- GAP_TICKS, 400, ticks with no mole lit between moles; minimum 1.
- UP_TICKS, 800, ticks a mole stays lit before it counts as a miss; minimum 1.
- GAME_TICKS, 30000, total ticks of play per game.
- SCORE_W, 8, width of the score and miss counters.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- btn  in  4  mole buttons, already synchronised, active-high level
- mole_onehot  out  4  lit mole, one-hot or zero, registered
- score  out  SCORE_W  hits this game, saturating
- misses  out  SCORE_W  timeouts plus wrong presses, saturating
- hit_pulse  out  1  one-cycle pulse per scored hit
- game_over  out  1  high while in OVER
- busy  out  1  high in GAP, UP or HIT
- state  out  3  current state encoding, for debug and the top-level FSM

Behaviour:
- Reset is asynchronous and active-high on clock clk.
- Reset values: state=IDLE, mole_onehot=0, score=0, misses=0, hit_pulse=0, game_over=0, busy=0, lfsr=8'hA5, all counters 0.
- Reset mid-game aborts immediately to IDLE with all outputs cleared.
- Tick: prescaler counts 0..TICK_DIV-1 and tick=1 when it equals TICK_DIV-1. The prescaler clears when start is accepted.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every clk cycle and never sits at zero. Candidate index = lfsr[1:0]. If the candidate equals the previous mole index, use (candidate+1) mod 4.
- Edge detect: btn_q registers btn. rise = btn & ~btn_q.
- IDLE: on start, go to GAP. Clear score and misses, load game_cnt=GAME_TICKS, load gap_cnt=GAP_TICKS.
- GAP: mole_onehot=0. On tick, decrement gap_cnt. When tick and gap_cnt==1, latch the mole index, set mole_onehot, load up_cnt=UP_TICKS and go to UP. The GAP state lasts exactly GAP_TICKS ticks.
- UP: evaluated in the cycle rise is seen; counter updates land on the next clock edge.
  - rise on the lit mole's bit: score+1, hit_pulse=1 for 1 cycle, go to HIT.
  - rise only on unlit bits: misses+1, stay in UP.
  - Multiple bits rising in the same cycle that include the lit bit count as a hit.
  - tick with up_cnt==1 and no hit: misses+1, go to GAP with gap_cnt reloaded.
- HIT: one cycle. mole_onehot=0, reload gap_cnt, go to GAP.
- Game timer: game_cnt decrements on tick in GAP, UP and HIT. When tick and game_cnt==1, go to OVER from any of those states. This takes priority over a same-cycle hit, miss or mole appearance: no score or miss update that cycle.
- OVER: mole_onehot=0, game_over=1, score and misses held. On start, behave as IDLE+start (new game).
- start is ignored in GAP, UP and HIT.
- Counters saturate at all-ones and never wrap.
- Output latency: mole_onehot and the state decode are registered, so they change on the clock edge of the transition.

Decomposition:
- Shared package game_pkg holds:
  - state encodings IDLE=0, GAP=1, UP=2, HIT=3, OVER=4;
  - NUM_MOLES=4;
  - LFSR_SEED=8'hA5;
  - the LFSR tap mask.
- One natural sub-module: lfsr8, which also serves other blocks. It provides enable, the seed on reset and an 8-bit output.
- Prescaler, timers and FSM stay in mole_round_scheduler.

Test Plan:
All scenarios use TICK_DIV=2, GAP_TICKS=2, UP_TICKS=3, GAME_TICKS=40, SCORE_W=8.
- Reset and first mole: reset then start -> state GAP. Exactly 4 cycles later mole_onehot = onehot of the first LFSR candidate from seed A5; busy=1, game_over=0.
- Hit: press the lit button 1 cycle after the mole appears -> hit_pulse for 1 cycle, score 0->1, HIT for 1 cycle, then GAP with mole_onehot=0.
- Wrong press then timeout: press an unlit button, hold no other buttons -> misses=1 immediately; after 6 cycles of UP the timeout gives misses=2 and the state returns to GAP. A held button does not retrigger.
- No repeat: force the LFSR so the candidate equals the previous mole -> lit mole is (prev+1) mod 4. Over 50 moles, no two consecutive moles are identical.
- Game end priority: align a hit with the final game tick -> state OVER, score unchanged, game_over=1. A later start clears score and misses, and the first mole appears 4 cycles later.
- Async reset mid-UP and saturation:
  - reset asserted mid-UP -> all outputs 0 immediately (no clk edge needed).
  - With SCORE_W=2 -> score sticks at 3 after 5 hits.
